mem_pipe_dmem: RTL and testbench
================================

MEM_PIPE_DMEM -- requirements
Module: mem_pipe_dmem

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, named as follows: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-002 SHALL have input MemRead, 1 bit: load request, sampled at the rising edge of clk.
REQ-003 SHALL have input MemWrite, 1 bit: store request, sampled at the rising edge of clk.
REQ-004 SHALL have input address, 32 bits: byte address; the word index is address[8:1].
REQ-005 SHALL have input memoryWriteData, 16 bits: store data.
REQ-006 SHALL have output stall, 1 bit, combinational: when high, the current request is not accepted and the requester holds its inputs.
REQ-007 SHALL have output memoryReadData, 16 bits, registered: load data.
REQ-008 SHALL have output readValid, 1 bit, registered: memoryReadData is valid this cycle.
REQ-009 SHALL have output addrError, 1 bit, registered: the access now in stage 2 was illegal.

Function
REQ-010 SHALL contain a 256 x 16 array; the array is not reset, and reset leaves its contents unchanged.
REQ-011 SHALL have two pipeline stages:
- s1 captures an accepted request at edge E0.
- At E1, s1 advances to s2; a load reads the array at E1.
- A store held in s2 writes the array at E2.
REQ-012 SHALL give loads a latency of two edges: a load accepted at E0 has readValid=1 and its data on memoryReadData after E1, for exactly one cycle.
REQ-013 SHALL treat a request as illegal when address[0]=1 or address[31:9]!=0:
- Illegal requests never write the array.
- An illegal load returns memoryReadData=0 with readValid=1.
- addrError=1 in the same cycle as that s2 result.
REQ-014 SHALL treat MemRead=1 together with MemWrite=1 as a store only: the read is dropped, and addrError pulses in s2 alongside the store.
REQ-015 SHALL place a bubble in s1 when MemRead=0 and MemWrite=0: no array access and readValid=0.
REQ-016 SHALL define the hazard condition as: s1 holds a legal load, s2 holds a legal store, and both have the same word index.
REQ-017 SHALL make back-to-back stores to the same word commit in order, with the last value winning.
REQ-018 SHALL make a load of any word not targeted by an in-flight store return the current array contents.
REQ-019 SHALL give output values while not stalled: memoryReadData holds its last value when readValid=0; addrError=0 unless REQ-013/REQ-014 applies.

Reset
REQ-020 SHALL, while rst_n=0, asynchronously clear the s1 and s2 valid/type flags and set stall=0, readValid=0, addrError=0, memoryReadData=16'h0000.
REQ-021 SHALL discard any store in flight (in s1 or s2) when reset asserts mid-operation; that store is never committed.
REQ-022 SHALL accept the first request at the first rising clk edge after rst_n deasserts.

Configuration
REQ-023 SHALL be configured by the macro DMEM_STORE_FWD_EN.
- Defined: on a hazard, s2 store data is forwarded into the load result; stall is tied to 0; zero-bubble throughput.
- Undefined: on a hazard, stall=1 for exactly one cycle; s1 holds the load; s2 commits the store; s1 inserts a bubble into s2. The load reads the updated array on the next edge, giving a load latency of 3 edges.
REQ-024 SHALL produce identical load data with and without DMEM_STORE_FWD_EN for any request sequence; only timing differs.

Verification
REQ-025 SHALL cover reset: with rst_n=0 mid-store to 0x10 of 0xBEEF, release reset and load 0x10 -> the pre-reset value is returned, not 0xBEEF; readValid=0 and memoryReadData=0 during reset.
REQ-026 SHALL cover a basic store then load: store 0x1234 @0x20, two idle cycles, load 0x20 -> readValid=1 with 0x1234 exactly 2 edges after the load.
REQ-027 SHALL cover the forwarding hazard: store 0xA5A5 @0x40, load 0x40 on the next cycle.
- FWD_EN defined: 0xA5A5 after 2 edges, stall never 1.
- FWD_EN undefined: stall=1 for one cycle, then 0xA5A5 after 3 edges.
REQ-028 SHALL cover illegal requests:
- Load @0x0001 -> addrError=1, readValid=1, data 0x0000.
- Store 0xFFFF @0x200 -> addrError=1; the array is unchanged (load @0x000 returns its old value).
REQ-029 SHALL cover simultaneous read and write: MemRead=1 and MemWrite=1 with 0x5555 @0x60 -> addrError pulse, readValid=0; a later load of 0x60 returns 0x5555.
REQ-030 SHALL cover stores back-to-back to the same word: 0x1111 then 0x2222 @0x80, then load 0x80 -> 0x2222.

Source files
------------

// File: rtl/mem_pipe_dmem.sv
// mem_pipe_dmem: two-stage pipelined 256 x 16 data memory.
//   s1 holds the request accepted at the last edge; on the next edge it moves
//   to s2, a load reads the array and the load result/error flags register.
//   A legal store sitting in s2 writes the array on the following edge.
// Optional feature macro: DMEM_STORE_FWD_EN
//   defined   - a load that hits the word of the store in s2 takes the store
//               data by forwarding; stall is tied low.
//   undefined - the same hazard stalls one cycle so the store commits first,
//               and the load then reads the updated array.
// Handshake: a request (MemRead or MemWrite high) is accepted at a rising
// edge only when stall is low in the cycle before that edge; while stall is
// high the requester keeps address/data/controls unchanged.
module mem_pipe_dmem (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] address,
  input  logic [15:0] memoryWriteData,
  output logic        stall,
  output logic [15:0] memoryReadData,
  output logic        readValid,
  output logic        addrError
);

  // Storage array; intentionally not reset.
  logic [15:0] mem_q [256];

  // Request decode
  logic       req_valid;
  logic       req_ill;
  logic [7:0] req_idx;

  // Stage 1: accepted request
  logic        s1_rd_q, s1_rd_d;       // load only (read+write is a store)
  logic        s1_wr_q, s1_wr_d;       // store, legal or not
  logic        s1_err_q, s1_err_d;     // addrError to report in s2
  logic        s1_ill_q, s1_ill_d;     // illegal address
  logic [7:0]  s1_idx_q, s1_idx_d;
  logic [15:0] s1_wdata_q, s1_wdata_d;

  // Stage 2: only a legal store needs to be remembered here
  logic        s2_wr_q, s2_wr_d;
  logic [7:0]  s2_idx_q, s2_idx_d;
  logic [15:0] s2_wdata_q, s2_wdata_d;

  // Registered outputs
  logic [15:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        aerr_q, aerr_d;

  logic hazard;
  logic stall_w;
  logic fwd_hit;

  assign req_valid = MemRead | MemWrite;
  assign req_ill   = address[0] | (|address[31:9]);
  assign req_idx   = address[8:1];

  // A legal load in s1 targets the word that the legal store in s2 writes
  // at this very edge; a plain array read would return the stale value.
  assign hazard = s1_rd_q & ~s1_ill_q & s2_wr_q & (s1_idx_q == s2_idx_q);

`ifdef DMEM_STORE_FWD_EN
  assign stall_w = 1'b0;
  assign fwd_hit = hazard;
`else
  assign stall_w = hazard;
  assign fwd_hit = 1'b0;
`endif

  assign stall          = stall_w;
  assign memoryReadData = rdata_q;
  assign readValid      = rvalid_q;
  assign addrError      = aerr_q;

  // Next-state for both stages and the registered load/error outputs.
  always_comb begin
    s1_rd_d    = s1_rd_q;
    s1_wr_d    = s1_wr_q;
    s1_err_d   = s1_err_q;
    s1_ill_d   = s1_ill_q;
    s1_idx_d   = s1_idx_q;
    s1_wdata_d = s1_wdata_q;
    s2_wr_d    = s2_wr_q;
    s2_idx_d   = s2_idx_q;
    s2_wdata_d = s2_wdata_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;
    aerr_d     = 1'b0;
    if (stall_w) begin
      // s1 keeps the load, s2 commits its store this edge and becomes a bubble.
      s2_wr_d = 1'b0;
    end else begin
      s1_rd_d    = MemRead & ~MemWrite;
      s1_wr_d    = MemWrite;
      s1_err_d   = req_valid & (req_ill | (MemRead & MemWrite));
      s1_ill_d   = req_ill;
      s1_idx_d   = req_idx;
      s1_wdata_d = memoryWriteData;
      s2_wr_d    = s1_wr_q & ~s1_ill_q;
      s2_idx_d   = s1_idx_q;
      s2_wdata_d = s1_wdata_q;
      rvalid_d   = s1_rd_q;
      aerr_d     = s1_err_q;
      if (s1_rd_q) begin
        if (s1_ill_q)     rdata_d = 16'h0000;
        else if (fwd_hit) rdata_d = s2_wdata_q;
        else              rdata_d = mem_q[s1_idx_q];
      end
    end
  end

  // Pipeline and output registers; reset flushes any in-flight store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_rd_q    <= 1'b0;
      s1_wr_q    <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_ill_q   <= 1'b0;
      s1_idx_q   <= 8'h00;
      s1_wdata_q <= 16'h0000;
      s2_wr_q    <= 1'b0;
      s2_idx_q   <= 8'h00;
      s2_wdata_q <= 16'h0000;
      rdata_q    <= 16'h0000;
      rvalid_q   <= 1'b0;
      aerr_q     <= 1'b0;
    end else begin
      s1_rd_q    <= s1_rd_d;
      s1_wr_q    <= s1_wr_d;
      s1_err_q   <= s1_err_d;
      s1_ill_q   <= s1_ill_d;
      s1_idx_q   <= s1_idx_d;
      s1_wdata_q <= s1_wdata_d;
      s2_wr_q    <= s2_wr_d;
      s2_idx_q   <= s2_idx_d;
      s2_wdata_q <= s2_wdata_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      aerr_q     <= aerr_d;
    end
  end

  // Array write from s2; s2_wr_q is cleared by reset so no stale store lands.
  always_ff @(posedge clk) begin
    if (s2_wr_q) mem_q[s2_idx_q] <= s2_wdata_q;
  end

endmodule

// File: tb/tb_mem_pipe_dmem.sv
// tb_mem_pipe_dmem: directed bench for mem_pipe_dmem with hand-computed
// expectations; follows DMEM_STORE_FWD_EN to pick the expected timing.
module tb_mem_pipe_dmem;

  logic        clk;
  logic        rst_n;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] address;
  logic [15:0] memoryWriteData;
  logic        stall;
  logic [15:0] memoryReadData;
  logic        readValid;
  logic        addrError;

  int n_cmp = 0;
  int n_err = 0;

`ifdef DMEM_STORE_FWD_EN
  localparam int HAZ_LAT = 2;
`else
  localparam int HAZ_LAT = 3;
`endif

  mem_pipe_dmem dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .MemRead         (MemRead),
    .MemWrite        (MemWrite),
    .address         (address),
    .memoryWriteData (memoryWriteData),
    .stall           (stall),
    .memoryReadData  (memoryReadData),
    .readValid       (readValid),
    .addrError       (addrError)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Check: one comparison, one line on mismatch
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are then stable for sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    MemRead         = 1'b0;
    MemWrite        = 1'b0;
    address         = 32'h0;
    memoryWriteData = 16'h0;
  endtask

  // Present a store for one accepting edge, then go idle.
  task automatic do_store(input logic [31:0] addr, input logic [15:0] data);
    MemWrite        = 1'b1;
    address         = addr;
    memoryWriteData = data;
    tick();
    idle_in();
  endtask

  // Issue a load, count edges until readValid, check latency, data and
  // that readValid drops after one cycle while data holds.
  task automatic load_check(input string tag, input logic [31:0] addr,
                            input logic [15:0] exp, input int exp_lat);
    int lat;
    MemRead = 1'b1;
    address = addr;
    tick();
    idle_in();
    lat = 1;
    do begin
      tick();
      lat++;
    end while (!readValid && lat < 8);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_data"}, memoryReadData, exp);
    tick();
    check({tag, "_rv_drop"}, readValid, 1'b0);
    check({tag, "_hold"}, memoryReadData, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_in();
    tick();
    tick();
    // Reset state
    check("rst_stall", stall, 1'b0);
    check("rst_rv", readValid, 1'b0);
    check("rst_aerr", addrError, 1'b0);
    check("rst_data", memoryReadData, 16'h0000);
    rst_n = 1'b1;

    // Seed words used later
    do_store(32'h000, 16'h7777);
    do_store(32'h010, 16'h0C0C);

    // Basic store then load, two idle cycles in between
    do_store(32'h020, 16'h1234);
    tick();
    tick();
    load_check("basic", 32'h020, 16'h1234, 2);

    // Forwarding hazard, with a second load waiting behind it
    do_store(32'h040, 16'hA5A5);
    MemRead = 1'b1;
    address = 32'h040;
    tick();
    MemRead = 1'b1;
    address = 32'h020;
`ifdef DMEM_STORE_FWD_EN
    check("haz_stall", stall, 1'b0);
    tick();
`else
    check("haz_stall", stall, 1'b1);
    tick();
    check("haz_stall_end", stall, 1'b0);
    check("haz_rv_wait", readValid, 1'b0);
    tick();
`endif
    check("haz_rv", readValid, 1'b1);
    check("haz_data", memoryReadData, 16'hA5A5);
    idle_in();
    tick();
    check("haz_next_rv", readValid, 1'b1);
    check("haz_next_data", memoryReadData, 16'h1234);
    tick();
    check("haz_rv_drop", readValid, 1'b0);

    // Illegal load: odd address
    MemRead = 1'b1;
    address = 32'h001;
    tick();
    idle_in();
    tick();
    check("ill_ld_aerr", addrError, 1'b1);
    check("ill_ld_rv", readValid, 1'b1);
    check("ill_ld_data", memoryReadData, 16'h0000);
    tick();
    check("ill_ld_aerr_drop", addrError, 1'b0);

    // Illegal store: out of range, must not alias onto word 0
    do_store(32'h200, 16'hFFFF);
    tick();
    check("ill_st_aerr", addrError, 1'b1);
    check("ill_st_rv", readValid, 1'b0);
    tick();
    tick();
    load_check("ill_st_w0", 32'h000, 16'h7777, 2);

    // Simultaneous read and write acts as a store
    MemRead         = 1'b1;
    MemWrite        = 1'b1;
    address         = 32'h060;
    memoryWriteData = 16'h5555;
    tick();
    idle_in();
    tick();
    check("rw_aerr", addrError, 1'b1);
    check("rw_rv", readValid, 1'b0);
    tick();
    tick();
    load_check("rw_ld", 32'h060, 16'h5555, 2);

    // Back-to-back stores to one word, load right behind
    do_store(32'h080, 16'h1111);
    do_store(32'h080, 16'h2222);
    load_check("b2b", 32'h080, 16'h2222, HAZ_LAT);

    // Reset while a store of 0xBEEF to 0x10 is in flight
    do_store(32'h010, 16'hBEEF);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rv", readValid, 1'b0);
    check("mid_rst_data", memoryReadData, 16'h0000);
    check("mid_rst_stall", stall, 1'b0);
    tick();
    tick();
    check("mid_rst_rv2", readValid, 1'b0);
    rst_n = 1'b1;
    load_check("post_rst", 32'h010, 16'h0C0C, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Guard against a stuck run
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
